// File: rtl/la_iopwrseq_pkg.sv
// la_iopwrseq_pkg: shared state encoding and helpers for the IO supply sequencer
package la_iopwrseq_pkg;
  typedef enum logic [2:0] {
    S_OFF, S_UP_EN, S_UP_WAIT, S_UP_SETTLE, S_ON, S_DN_ISO, S_DN_SETTLE, S_FAULT
  } state_t;
  function automatic int lowest_zero(input logic [63:0] v, input int n);
    lowest_zero = 0;
    for (int k = n - 1; k >= 0; k--) if (!v[k]) lowest_zero = k;
  endfunction
endpackage

// File: rtl/la_iopwrseq_dsync.sv
// la_dsync: two-flop synchroniser for an asynchronous single-bit input
module la_dsync #(
  parameter PROP = "DEFAULT"
) (
  input  logic clk,
  input  logic nreset,
  input  logic in,
  output logic out
);
  localparam int unused_prop = $bits(PROP);
  logic [1:0] sync_q;
  logic [1:0] sync_d;
  always_comb sync_d = {sync_q[0], in};
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) sync_q <= '0;
    else sync_q <= sync_d;
  assign out = sync_q[1];
endmodule

// File: rtl/la_iopwrseq.sv
// la_iopwrseq: powers N supply domains up in ascending order and down in reverse,
// gating isolation release on synchronised power-good plus a settle delay.
module la_iopwrseq
  import la_iopwrseq_pkg::*;
#(
  parameter int N = 4,
  parameter int CW = 16,
  parameter int SETTLE = 100,
  parameter int TIMEOUT = 1000,
  parameter PROP = "DEFAULT"
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 req,
  input  logic                 clear,
  input  logic [N-1:0]         pgood,
  output logic [N-1:0]         en,
  output logic [N-1:0]         iso,
  output logic                 on,
  output logic                 busy,
  output logic                 fault,
  output logic [$clog2(N)-1:0] fault_ch
);
  localparam int IW = $clog2(N);
  logic [N-1:0] pgood_s;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d, fault_ch_q, fault_ch_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0] en_q, en_d, iso_q, iso_d;
  logic on_q, on_d, busy_q, busy_d, fault_q, fault_d;
  for (genvar i = 0; i < N; i++) begin : g_sync
    la_dsync #(.PROP(PROP)) u_sync (
      .clk   (clk),
      .nreset(nreset),
      .in    (pgood[i]),
      .out   (pgood_s[i])
    );
  end
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    en_d = en_q;
    iso_d = iso_q;
    fault_d = fault_q;
    fault_ch_d = fault_ch_q;
    case (state_q)
      S_OFF: if (req) begin
        state_d = S_UP_EN;
        idx_d = '0;
      end
      S_UP_EN: if (!req) state_d = S_DN_ISO;
      else begin
        en_d[idx_q] = 1'b1;
        cnt_d = '0;
        state_d = S_UP_WAIT;
      end
      S_UP_WAIT: if (!req) state_d = S_DN_ISO;
      else if (pgood_s[idx_q]) begin
        cnt_d = '0;
        state_d = S_UP_SETTLE;
      end else if (cnt_q == CW'(TIMEOUT - 1)) begin
        fault_ch_d = idx_q;
        state_d = S_FAULT;
      end else cnt_d = cnt_q + 1'b1;
      S_UP_SETTLE: if (!req) state_d = S_DN_ISO;
      else if (cnt_q == CW'(SETTLE - 1)) begin
        iso_d[idx_q] = 1'b0;
        cnt_d = '0;
        state_d = (idx_q == IW'(N - 1)) ? S_ON : S_UP_EN;
        idx_d = (idx_q == IW'(N - 1)) ? idx_q : idx_q + 1'b1;
      end else cnt_d = cnt_q + 1'b1;
      // a lost supply outranks a power-down request
      S_ON: if (!(&pgood_s)) begin
        fault_ch_d = IW'(lowest_zero(64'(pgood_s), N));
        state_d = S_FAULT;
      end else if (!req) begin
        idx_d = IW'(N - 1);
        state_d = S_DN_ISO;
      end
      S_DN_ISO: begin
        iso_d[idx_q] = 1'b1;
        en_d[idx_q] = 1'b0;
        cnt_d = '0;
        state_d = S_DN_SETTLE;
      end
      S_DN_SETTLE: if (cnt_q == CW'(SETTLE - 1)) begin
        cnt_d = '0;
        state_d = (idx_q == '0) ? S_OFF : S_DN_ISO;
        idx_d = (idx_q == '0) ? idx_q : idx_q - 1'b1;
      end else cnt_d = cnt_q + 1'b1;
      S_FAULT: if (clear && !req) begin
        fault_d = 1'b0;
        fault_ch_d = '0;
        state_d = S_OFF;
      end
      default: state_d = S_OFF;
    endcase
    if (state_d == S_FAULT && state_q != S_FAULT) begin
      en_d = '0;
      iso_d = '1;
      fault_d = 1'b1;
    end
    on_d = state_q == S_ON;
    busy_d = !(state_q inside {S_OFF, S_ON, S_FAULT});
  end
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      state_q <= S_OFF;
      idx_q <= '0;
      cnt_q <= '0;
      en_q <= '0;
      iso_q <= '1;
      on_q <= 1'b0;
      busy_q <= 1'b0;
      fault_q <= 1'b0;
      fault_ch_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      en_q <= en_d;
      iso_q <= iso_d;
      on_q <= on_d;
      busy_q <= busy_d;
      fault_q <= fault_d;
      fault_ch_q <= fault_ch_d;
    end
  assign en = en_q;
  assign iso = iso_q;
  assign on = on_q;
  assign busy = busy_q;
  assign fault = fault_q;
  assign fault_ch = fault_ch_q;
endmodule

// File: tb/tb_la_iopwrseq.sv
// tb_la_iopwrseq: scoreboard bench; stimulus queues timed expectations, a monitor checks them
module tb_la_iopwrseq;
  logic clk, nreset, req, clear;
  logic [3:0] pgood, en, iso;
  logic on, busy, fault;
  logic [1:0] fault_ch;
  int cyc = 0, total = 0, bad = 0;
  event chk;
  localparam logic [12:0] M_EN = 13'h000F, M_ISO = 13'h00F0, M_ON = 13'h0100;
  localparam logic [12:0] M_BUSY = 13'h0200, M_FAULT = 13'h0400, M_FCH = 13'h1800;
  localparam logic [12:0] M_ALL = 13'h1FFF;
  typedef struct {
    int due;
    logic [12:0] mask;
    logic [12:0] exp;
    string name;
  } item_t;
  item_t sb[$];
  la_iopwrseq #(.N(4), .CW(16), .SETTLE(4), .TIMEOUT(16), .PROP("DEFAULT")) dut (
    .clk(clk), .nreset(nreset), .req(req), .clear(clear), .pgood(pgood),
    .en(en), .iso(iso), .on(on), .busy(busy), .fault(fault), .fault_ch(fault_ch)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic expect_at(input int dly, input logic [12:0] m, input logic [12:0] v, input string nm);
    item_t it;
    int p;
    it.due = cyc + dly;
    it.mask = m;
    it.exp = v;
    it.name = nm;
    p = sb.size();
    for (int i = 0; i < sb.size(); i++)
      if (sb[i].due > it.due) begin
        p = i;
        break;
      end
    sb.insert(p, it);
  endtask
  initial begin
    item_t e;
    logic [12:0] obs;
    forever begin
      @(posedge clk or chk);
      #1;
      obs = {fault_ch, fault, busy, on, iso, en};
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        total++;
        if ((obs & e.mask) !== (e.exp & e.mask)) begin
          bad++;
          $display("FAIL %s: got %h want %h (mask %h) at cycle %0d", e.name, obs & e.mask, e.exp & e.mask, e.mask, cyc);
        end
      end
    end
  end
  initial begin
    nreset = 1'b0; req = 1'b0; clear = 1'b0; pgood = 4'hF;
    repeat (2) @(negedge clk);
    expect_at(1, M_ALL, 13'h00F0, "reset_state");
    @(negedge clk); nreset = 1'b1;
    repeat (3) @(negedge clk);
    // power-up with pgood high
    req = 1'b1;
    expect_at(1, M_EN, 13'h0000, "up_en_none");
    expect_at(2, M_EN | M_BUSY, 13'h0201, "up_en0");
    expect_at(6, M_ISO, 13'h00F0, "up_iso_held");
    expect_at(7, M_ISO, 13'h00E0, "up_iso0");
    expect_at(8, M_EN, 13'h0003, "up_en1");
    expect_at(14, M_EN, 13'h0007, "up_en2");
    expect_at(20, M_EN, 13'h000F, "up_en3");
    expect_at(25, M_ON | M_BUSY, 13'h0200, "on_not_yet");
    expect_at(26, M_ALL, 13'h010F, "on_up");
    repeat (30) @(negedge clk);
    // power-down
    req = 1'b0;
    expect_at(1, M_EN | M_ISO, 13'h000F, "dn_start");
    expect_at(2, M_EN | M_ISO | M_ON, 13'h0087, "dn_dom3");
    expect_at(7, M_EN | M_ISO, 13'h00C3, "dn_dom2");
    expect_at(12, M_EN | M_ISO, 13'h00E1, "dn_dom1");
    expect_at(17, M_EN | M_ISO, 13'h00F0, "dn_dom0");
    expect_at(21, M_BUSY, 13'h0200, "dn_busy");
    expect_at(22, M_ALL, 13'h00F0, "dn_off");
    repeat (25) @(negedge clk);
    // timeout on domain 2
    pgood = 4'b1011;
    repeat (3) @(negedge clk);
    req = 1'b1;
    expect_at(29, M_FAULT | M_EN, 13'h0007, "to_wait");
    expect_at(30, M_FAULT | M_FCH | M_EN | M_ISO, 13'h14F0, "to_fault");
    expect_at(31, M_BUSY, 13'h0000, "to_busy");
    repeat (35) @(negedge clk);
    clear = 1'b1;
    expect_at(3, M_FAULT | M_FCH, 13'h1400, "fault_hold");
    repeat (4) @(negedge clk);
    req = 1'b0;
    expect_at(1, M_FAULT | M_EN | M_ISO | M_BUSY, 13'h00F0, "fault_clear");
    repeat (2) @(negedge clk);
    clear = 1'b0; pgood = 4'hF;
    repeat (3) @(negedge clk);
    // two supplies drop while on
    req = 1'b1;
    expect_at(26, M_ON, 13'h0100, "on_again");
    repeat (30) @(negedge clk);
    pgood = 4'b0101;
    expect_at(2, M_FAULT, 13'h0000, "drop_sync");
    expect_at(3, M_FAULT | M_FCH | M_EN | M_ISO, 13'h0CF0, "drop_fault");
    repeat (5) @(negedge clk);
    req = 1'b0; clear = 1'b1;
    repeat (2) @(negedge clk);
    clear = 1'b0; pgood = 4'hF;
    expect_at(1, M_FAULT, 13'h0000, "drop_clear");
    repeat (3) @(negedge clk);
    // abort while domain 2 settles
    req = 1'b1;
    repeat (16) @(negedge clk);
    req = 1'b0;
    expect_at(1, M_EN | M_ISO, 13'h00C7, "ab_pre");
    expect_at(2, M_EN | M_ISO, 13'h00C3, "ab_dom2");
    expect_at(7, M_EN | M_ISO, 13'h00E1, "ab_dom1");
    expect_at(12, M_EN | M_ISO, 13'h00F0, "ab_dom0");
    expect_at(17, M_BUSY, 13'h0000, "ab_off");
    for (int i = 1; i <= 20; i++) expect_at(i, 13'h0008, 13'h0000, "ab_en3");
    repeat (25) @(negedge clk);
    // async reset mid UP_WAIT
    pgood = 4'b1110;
    req = 1'b1;
    expect_at(5, M_EN | M_BUSY, 13'h0201, "wait_dom0");
    repeat (6) @(negedge clk);
    #2 nreset = 1'b0;
    expect_at(0, M_ALL, 13'h00F0, "async_rst");
    ->chk;
    #2 nreset = 1'b1; pgood = 4'hF;
    expect_at(1, M_EN, 13'h0000, "rs_none");
    expect_at(2, M_EN, 13'h0001, "rs_en0");
    expect_at(26, M_ON | M_EN | M_ISO, 13'h010F, "rs_on");
    repeat (30) @(negedge clk);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL leftover: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
